// File: rtl/noc_mem_responder.sv
// noc0 memory-side endpoint: accepts write/read requests into a line-addressed
// local memory and returns WR_RESP / RD_RESP messages to the requesting tile.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif

module noc_mem_responder #(
    parameter logic [7:0] SRC_X = 8'd0,
    parameter logic [7:0] SRC_Y = 8'd0,
    parameter int         DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       noc0_mem_val,
    input  logic [`NOC_DATA_WIDTH-1:0] noc0_mem_data,
    output logic                       mem_noc0_rdy,
    output logic                       mem_noc0_val,
    output logic [`NOC_DATA_WIDTH-1:0] mem_noc0_data,
    input  logic                       noc0_mem_rdy
);
    localparam int W     = `NOC_DATA_WIDTH;
    localparam int BYTES = W / 8;
    localparam int BW    = $clog2(BYTES);
    localparam int AW    = $clog2(DEPTH);

    localparam logic [7:0] WR_REQ  = 8'h10;
    localparam logic [7:0] WR_RESP = 8'h11;
    localparam logic [7:0] RD_REQ  = 8'h20;
    localparam logic [7:0] RD_RESP = 8'h21;

    typedef enum logic [2:0] {
        IDLE, S_WR_DATA, S_WR_RESP, S_RD_HDR, S_RD_DATA, S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [16:0]   cnt_q, cnt_d;
    logic [7:0]    rx_q, rx_d, ry_q, ry_d;
    logic [63:0]   addr_q, addr_d;
    logic [15:0]   size_q, size_d;
    logic          mem_we;

    logic [W-1:0] mem [DEPTH];

    // Request header fields
    logic [7:0]    h_src_x, h_src_y, h_len, h_type;
    logic [63:0]   h_addr;
    logic [15:0]   h_size;
    logic [16:0]   h_n;
    logic [AW-1:0] h_ptr;
    logic          unused_bits;

    assign h_src_x = noc0_mem_data[W-17 -: 8];
    assign h_src_y = noc0_mem_data[W-25 -: 8];
    assign h_len   = noc0_mem_data[W-33 -: 8];
    assign h_type  = noc0_mem_data[W-41 -: 8];
    assign h_addr  = noc0_mem_data[W-49 -: 64];
    assign h_size  = noc0_mem_data[W-113 -: 16];
    assign h_ptr   = h_addr[BW +: AW];
    assign h_n     = ({1'b0, h_size} + 17'(BYTES - 1)) >> BW;
    assign unused_bits = ^{noc0_mem_data[W-1 -: 16], noc0_mem_data[W-129:0]};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        addr_d  = addr_q;
        size_d  = size_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (noc0_mem_val) begin
                    rx_d   = h_src_x;
                    ry_d   = h_src_y;
                    addr_d = h_addr;
                    size_d = h_size;
                    ptr_d  = h_ptr;
                    cnt_d  = {9'd0, h_len};
                    case (h_type)
                        WR_REQ:  state_d = (h_len != 8'd0) ? S_WR_DATA : S_WR_RESP;
                        RD_REQ: begin
                            cnt_d   = h_n;
                            state_d = S_RD_HDR;
                        end
                        default: state_d = (h_len != 8'd0) ? S_DRAIN : IDLE;
                    endcase
                end
            end
            S_WR_DATA: begin
                if (noc0_mem_val) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    cnt_d  = cnt_q - 17'd1;
                    if (cnt_q == 17'd1) state_d = S_WR_RESP;
                end
            end
            S_DRAIN: begin
                if (noc0_mem_val) begin
                    cnt_d = cnt_q - 17'd1;
                    if (cnt_q == 17'd1) state_d = IDLE;
                end
            end
            S_WR_RESP: begin
                if (noc0_mem_rdy) state_d = IDLE;
            end
            S_RD_HDR: begin
                if (noc0_mem_rdy) state_d = (cnt_q != 17'd0) ? S_RD_DATA : IDLE;
            end
            S_RD_DATA: begin
                if (noc0_mem_rdy) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - 17'd1;
                    if (cnt_q == 17'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake signals come from registered state only
    always_comb begin
        mem_noc0_rdy  = (state_q == IDLE) || (state_q == S_WR_DATA) || (state_q == S_DRAIN);
        mem_noc0_val  = (state_q == S_WR_RESP) || (state_q == S_RD_HDR) || (state_q == S_RD_DATA);
        mem_noc0_data = '0;
        if (state_q == S_WR_RESP || state_q == S_RD_HDR) begin
            mem_noc0_data[W-1 -: 8]    = rx_q;
            mem_noc0_data[W-9 -: 8]    = ry_q;
            mem_noc0_data[W-17 -: 8]   = SRC_X;
            mem_noc0_data[W-25 -: 8]   = SRC_Y;
            mem_noc0_data[W-33 -: 8]   = (state_q == S_RD_HDR) ? cnt_q[7:0] : 8'd0;
            mem_noc0_data[W-41 -: 8]   = (state_q == S_RD_HDR) ? RD_RESP : WR_RESP;
            mem_noc0_data[W-49 -: 64]  = addr_q;
            mem_noc0_data[W-113 -: 16] = size_q;
        end else if (state_q == S_RD_DATA) begin
            mem_noc0_data = mem[ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            addr_q  <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
        end
    end

    // Memory is deliberately not reset; a partial write is dropped when rst hits
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[ptr_q] <= noc0_mem_data;
    end
endmodule

// File: tb/tb_noc_mem_responder.sv
// Randomized self-checking bench for noc_mem_responder against a line-array
// memory model and header-format reference.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif

module tb_noc_mem_responder;
    localparam int W     = `NOC_DATA_WIDTH;
    localparam int BYTES = W / 8;
    localparam int DEPTH = 256;
    localparam logic [7:0] SX = 8'd0;
    localparam logic [7:0] SY = 8'd1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         noc0_mem_val = 1'b0;
    logic [W-1:0] noc0_mem_data = '0;
    logic         mem_noc0_rdy;
    logic         mem_noc0_val;
    logic [W-1:0] mem_noc0_data;
    logic         noc0_mem_rdy = 1'b1;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] mm [DEPTH];
    logic [W-1:0] body_q [$];

    always #5 clk = ~clk;

    noc_mem_responder #(.SRC_X(SX), .SRC_Y(SY), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .noc0_mem_val(noc0_mem_val), .noc0_mem_data(noc0_mem_data), .mem_noc0_rdy(mem_noc0_rdy),
        .mem_noc0_val(mem_noc0_val), .mem_noc0_data(mem_noc0_data), .noc0_mem_rdy(noc0_mem_rdy)
    );

    function automatic logic [W-1:0] mk_hdr(input logic [7:0] dx, input logic [7:0] dy,
                                            input logic [7:0] sx, input logic [7:0] sy,
                                            input logic [7:0] len, input logic [7:0] typ,
                                            input logic [63:0] a, input logic [15:0] sz);
        logic [W-1:0] h;
        h = '0;
        h[W-1 -: 8]    = dx;
        h[W-9 -: 8]    = dy;
        h[W-17 -: 8]   = sx;
        h[W-25 -: 8]   = sy;
        h[W-33 -: 8]   = len;
        h[W-41 -: 8]   = typ;
        h[W-49 -: 64]  = a;
        h[W-113 -: 16] = sz;
        return h;
    endfunction

    function automatic logic [W-1:0] rnd_line();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int line_of(input logic [63:0] a);
        return int'((a / 64'(BYTES)) % 64'(DEPTH));
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_flit(input logic [W-1:0] d);
        int t = 0;
        noc0_mem_val  = 1'b1;
        noc0_mem_data = d;
        while (!mem_noc0_rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (mem_noc0_rdy !== 1'b1) begin
            errors++;
            $display("FAIL send_rdy_timeout rdy=%b required=1", mem_noc0_rdy);
        end
        @(negedge clk);
        noc0_mem_val = 1'b0;
    endtask

    task automatic recv_flit(input string nm, input logic [W-1:0] exp, input bit stall, output int waited);
        int t = 0;
        bit done = 0, have = 0;
        logic [W-1:0] held, got;
        got = '0;
        while (!done && t < 200) begin
            noc0_mem_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mem_noc0_val === 1'b1) begin
                if (have) begin
                    checks++;
                    if (mem_noc0_data !== held) begin
                        errors++;
                        $display("FAIL %s_stable data=%h required=%h", nm, mem_noc0_data, held);
                    end
                end
                held = mem_noc0_data;
                have = 1;
                if (noc0_mem_rdy) begin
                    got  = mem_noc0_data;
                    done = 1;
                end
            end
            @(negedge clk);
            if (!done) t++;
        end
        noc0_mem_rdy = 1'b1;
        waited = t;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout val=%b required=1", nm, mem_noc0_val);
        end else if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", nm, got, exp);
        end
    endtask

    task automatic check_idle(input string nm);
        checks++;
        if (mem_noc0_val !== 1'b0 || mem_noc0_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s val=%b rdy=%b required val=0 rdy=1", nm, mem_noc0_val, mem_noc0_rdy);
        end
    endtask

    task automatic check_resp_now(input string nm);
        checks++;
        if (mem_noc0_val !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency val=%b required=1", nm, mem_noc0_val);
        end
    endtask

    // Sends WR_REQ with body_q as payload, checks the WR_RESP
    task automatic do_write(input logic [7:0] sx, input logic [7:0] sy, input logic [63:0] a,
                            input logic [15:0] sz, input bit stall);
        int n = body_q.size();
        int ln = line_of(a);
        int w;
        send_flit(mk_hdr(SX, SY, sx, sy, 8'(n), 8'h10, a, sz));
        for (int i = 0; i < n; i++) begin
            send_flit(body_q[i]);
            mm[(ln + i) % DEPTH] = body_q[i];
        end
        check_resp_now("wr_resp");
        recv_flit("wr_resp_hdr", mk_hdr(sx, sy, SX, SY, 8'd0, 8'h11, a, sz), stall, w);
        body_q.delete();
    endtask

    task automatic do_read(input logic [7:0] sx, input logic [7:0] sy, input logic [63:0] a,
                           input logic [15:0] sz, input bit stall);
        int n = (int'(sz) + BYTES - 1) / BYTES;
        int ln = line_of(a);
        int w;
        send_flit(mk_hdr(SX, SY, sx, sy, 8'd0, 8'h20, a, sz));
        check_resp_now("rd_resp");
        recv_flit("rd_resp_hdr", mk_hdr(sx, sy, SX, SY, 8'(n), 8'h21, a, sz), stall, w);
        for (int i = 0; i < n; i++) begin
            recv_flit("rd_data", mm[(ln + i) % DEPTH], stall, w);
            if (!stall) begin
                checks++;
                if (w != 0) begin
                    errors++;
                    $display("FAIL rd_throughput wait=%0d required=0", w);
                end
            end
        end
        check_idle("rd_done_idle");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset_hs");
        checks++;
        if (mem_noc0_data !== '0) begin
            errors++;
            $display("FAIL reset_data data=%h required=0", mem_noc0_data);
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset_hs");
        checks++;
        if (mem_noc0_data !== '0) begin
            errors++;
            $display("FAIL post_reset_data data=%h required=0", mem_noc0_data);
        end
    endtask

    task automatic test_write_read();
        body_q.push_back(rnd_line());
        body_q.push_back(rnd_line());
        do_write(8'd1, 8'd0, 64'h40, 16'd128, 1'b0);
        do_read(8'd1, 8'd0, 64'h40, 16'd100, 1'b0);
    endtask

    task automatic test_size0_wrap();
        do_read(8'd2, 8'd3, 64'h40, 16'd0, 1'b0);
        do_write(8'd4, 8'd5, 64'h80, 16'd0, 1'b0);
        body_q.push_back(rnd_line());
        body_q.push_back(rnd_line());
        do_write(8'd1, 8'd0, 64'(DEPTH - 1) * 64'(BYTES), 16'd128, 1'b0);
        do_read(8'd1, 8'd0, 64'(DEPTH - 1) * 64'(BYTES), 16'd128, 1'b0);
    endtask

    task automatic test_stall_random();
        for (int it = 0; it < 10; it++) begin
            int n = $urandom_range(1, 4);
            logic [63:0] a;
            a = {32'($urandom), 32'(0)} + 64'($urandom_range(0, 63)) * 64'(BYTES)
                + 64'($urandom_range(0, BYTES - 1));
            for (int i = 0; i < n; i++) body_q.push_back(rnd_line());
            do_write(8'($urandom), 8'($urandom), a, 16'(n * BYTES), 1'b1);
            do_read(8'($urandom), 8'($urandom), a, 16'($urandom_range(1, n * BYTES)), 1'b1);
        end
    endtask

    task automatic test_drain();
        send_flit(mk_hdr(SX, SY, 8'd7, 8'd7, 8'd3, 8'h55, 64'h0, 16'd0));
        for (int i = 0; i < 3; i++) send_flit(rnd_line());
        for (int i = 0; i < 4; i++) begin
            check_idle("drain_no_resp");
            @(negedge clk);
        end
        send_flit(mk_hdr(SX, SY, 8'd7, 8'd7, 8'd0, 8'h55, 64'h0, 16'd0));
        check_idle("unknown_len0_idle");
        body_q.push_back(rnd_line());
        do_write(8'd3, 8'd2, 64'h100, 16'd64, 1'b0);
        do_read(8'd3, 8'd2, 64'h100, 16'd64, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        d = rnd_line();
        send_flit(mk_hdr(SX, SY, 8'd1, 8'd1, 8'd3, 8'h10, 64'd10 * 64'(BYTES), 16'd192));
        send_flit(d);
        mm[10] = d;
        rst = 1'b1;
        @(negedge clk);
        check_idle("mid_reset_hs");
        rst = 1'b0;
        @(negedge clk);
        check_idle("after_mid_reset_hs");
        do_read(8'd1, 8'd1, 64'd10 * 64'(BYTES), 16'd64, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_read();
        test_size0_wrap();
        test_stall_random();
        test_drain();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
